// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C slave with pointer-addressed register bank, sys_clk oversampled
module i2c_slave_regfile #(
    parameter logic [6:0] I2C_ADR     = 7'h27,
    parameter int         REG_NUM     = 16,
    parameter int         PTR_W       = 4,
    parameter int         FILT_CYCLES = 3,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   scl_i,
    input  logic                   sda_i,
    output logic                   sda_oe,
    output logic [REG_NUM*8-1:0]   reg_flat,
    output logic                   wr_pulse,
    output logic [PTR_W-1:0]       wr_addr,
    output logic [7:0]             wr_data,
    output logic                   busy
);

    localparam int FC_W = $clog2(FILT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_SKIP
    } state_t;

    // Index 0 carries SCL, index 1 carries SDA; idle bus level is high.
    logic [1:0]      sync1, sync2, filt, filt_d;
    logic [FC_W-1:0] fcnt [2];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {sda_i, scl_i};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FC_W'(FILT_CYCLES - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det, sda_bit;
    assign scl_rise  = filt[0] & ~filt_d[0];
    assign scl_fall  = ~filt[0] & filt_d[0];
    assign start_det = filt[0] & filt_d[0] & ~filt[1] & filt_d[1];
    assign stop_det  = filt[0] & filt_d[0] & filt[1] & ~filt_d[1];
    assign sda_bit   = filt[1];

    state_t           state;
    logic [3:0]       cnt;
    logic [7:0]       sreg;
    logic [6:0]       tx;
    logic             ack_ok;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic [7:0]       regs [REG_NUM];

    assign ptr_next = (ptr == PTR_W'(REG_NUM - 1)) ? '0 : ptr + 1'b1;

    for (genvar k = 0; k < REG_NUM; k++) begin : g_flat
        assign reg_flat[8*k +: 8] = regs[k];
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sreg     <= '0;
            tx       <= '0;
            ack_ok   <= 1'b0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            for (int k = 0; k < REG_NUM; k++) regs[k] <= RESET_VAL;
        end else begin
            wr_pulse <= 1'b0;
            if (start_det) begin
                state  <= S_ADDR;
                cnt    <= '0;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
            end else if (stop_det) begin
                state  <= S_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_PTR, S_WR: begin
                        if (scl_rise) begin
                            sreg <= {sreg[6:0], sda_bit};
                            cnt  <= cnt + 1'b1;
                        end else if (scl_fall && cnt == 4'd8) begin
                            cnt <= '0;
                            case (state)
                                S_ADDR: begin
                                    // General call (address 0) is deliberately left unacknowledged.
                                    if (sreg[7:1] == I2C_ADR && sreg[7:1] != 7'd0) begin
                                        state  <= S_ADDR_ACK;
                                        sda_oe <= 1'b1;
                                    end else begin
                                        state <= S_SKIP;
                                    end
                                end
                                S_PTR: begin
                                    if ({1'b0, sreg} < 9'(REG_NUM)) begin
                                        ptr    <= sreg[PTR_W-1:0];
                                        state  <= S_PTR_ACK;
                                        sda_oe <= 1'b1;
                                    end else begin
                                        state <= S_SKIP;
                                    end
                                end
                                default: begin
                                    regs[ptr] <= sreg;
                                    wr_pulse  <= 1'b1;
                                    wr_addr   <= ptr;
                                    wr_data   <= sreg;
                                    ptr       <= ptr_next;
                                    state     <= S_WR_ACK;
                                    sda_oe    <= 1'b1;
                                end
                            endcase
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            cnt <= '0;
                            if (sreg[0]) begin
                                state  <= S_RD;
                                tx     <= regs[ptr][6:0];
                                sda_oe <= ~regs[ptr][7];
                            end else begin
                                state  <= S_PTR;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_PTR_ACK, S_WR_ACK: begin
                        if (scl_fall) begin
                            state  <= S_WR;
                            sda_oe <= 1'b0;
                        end
                    end
                    S_RD: begin
                        if (scl_rise) begin
                            cnt <= cnt + 1'b1;
                        end else if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                ptr    <= ptr_next;
                                state  <= S_RD_ACK;
                            end else begin
                                sda_oe <= ~tx[6];
                                tx     <= {tx[5:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            ack_ok <= ~sda_bit;
                        end else if (scl_fall) begin
                            cnt <= '0;
                            if (ack_ok) begin
                                state  <= S_RD;
                                tx     <= regs[ptr][6:0];
                                sda_oe <= ~regs[ptr][7];
                            end else begin
                                state  <= S_SKIP;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - scoreboard bench for i2c_slave_regfile
module tb_i2c_slave_regfile;

    logic         sys_clk = 1'b0;
    logic         rst_n   = 1'b0;
    logic         scl_m   = 1'b1;
    logic         sda_m   = 1'b1;
    logic         scl_i, sda_i;
    logic         sda_oe, wr_pulse, busy;
    logic [127:0] reg_flat;
    logic [3:0]   wr_addr;
    logic [7:0]   wr_data;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_regfile dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .scl_i   (scl_i),
        .sda_i   (sda_i),
        .sda_oe  (sda_oe),
        .reg_flat(reg_flat),
        .wr_pulse(wr_pulse),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           fall_cyc = 0;
    int           last_lat = -1;
    bit           oe_seen = 1'b0;
    bit           glitch = 1'b0;
    logic         oe_prev = 1'b0;
    logic [11:0]  exp_wr[$];
    logic [7:0]   exp_rd[$];
    logic [127:0] mdl_flat = '0;

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        logic [11:0] e;
        if (sda_oe && !oe_prev) begin
            last_lat = cyc - fall_cyc;
            oe_seen  = 1'b1;
        end
        oe_prev = sda_oe;
        if (rst_n && wr_pulse) begin
            tests++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    fails++;
                    $display("FAIL wr_commit: got addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic bit_io(input logic b, output logic s);
        sda_m = b;
        if (glitch) begin
            wait_cyc(3); scl_m = 1'b1; wait_cyc(1); scl_m = 1'b0; wait_cyc(4);
        end else begin
            wait_cyc(8);
        end
        scl_m = 1'b1; wait_cyc(8);
        s = sda_i;    wait_cyc(8);
        scl_m = 1'b0; fall_cyc = cyc; wait_cyc(8);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_cyc(8);
        scl_m = 1'b1; wait_cyc(8);
        sda_m = 1'b0; wait_cyc(8);
        scl_m = 1'b0; wait_cyc(8);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_cyc(8);
        scl_m = 1'b1; wait_cyc(8);
        sda_m = 1'b1; wait_cyc(8);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        ack = ~s;
    endtask

    task automatic wr_data_byte(input logic [3:0] a, input logic [7:0] d, output logic ack);
        exp_wr.push_back({a, d});
        mdl_flat[8*a +: 8] = d;
        wr_byte(d, ack);
    endtask

    task automatic rd_byte(input logic master_ack, input logic [7:0] exp, input string nm);
        logic       s;
        logic [7:0] b, e;
        exp_rd.push_back(exp);
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            b[i] = s;
        end
        bit_io(~master_ack, s);
        e = exp_rd.pop_front();
        tests++;
        if (b !== e) begin
            fails++;
            $display("FAIL %s: read %h, required %h", nm, b, e);
        end
    endtask

    task automatic test_reset;
        wait_cyc(3);
        tests++;
        if ({sda_oe, wr_pulse, wr_addr, wr_data, busy} !== 15'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", {sda_oe, wr_pulse, wr_addr, wr_data, busy});
        end
        tests++;
        if (reg_flat !== mdl_flat) begin
            fails++;
            $display("FAIL reset_regs: got %h, required %h", reg_flat, mdl_flat);
        end
        rst_n = 1'b1;
        wait_cyc(10);
    endtask

    task automatic test_write;
        logic [2:0] a;
        i2c_start;
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_start: got %b, required 1", busy); end
        wr_byte(8'h4E, a[2]);
        wr_byte(8'h03, a[1]);
        wr_data_byte(4'd3, 8'hA5, a[0]);
        tests++;
        if (last_lat < 1 || last_lat > 6) begin
            fails++;
            $display("FAIL oe_latency: got %0d cycles, required 1..6", last_lat);
        end
        i2c_stop;
        tests++;
        if (a !== 3'b111) begin fails++; $display("FAIL write_acks: got %b, required 111", a); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_stop: got %b, required 0", busy); end
        tests++;
        if (reg_flat !== mdl_flat || exp_wr.size() != 0) begin
            fails++;
            $display("FAIL write_regs: got %h, required %h, pending writes %0d", reg_flat, mdl_flat, exp_wr.size());
        end
    endtask

    task automatic test_burst_wrap;
        logic [4:0] a;
        i2c_start;
        wr_byte(8'h4E, a[4]);
        wr_byte(8'h0F, a[3]);
        wr_data_byte(4'd15, 8'h11, a[2]);
        wr_data_byte(4'd0,  8'h22, a[1]);
        wr_data_byte(4'd1,  8'h33, a[0]);
        i2c_stop;
        tests++;
        if (a !== 5'b11111) begin fails++; $display("FAIL burst_acks: got %b, required 11111", a); end
        tests++;
        if (reg_flat !== mdl_flat || exp_wr.size() != 0) begin
            fails++;
            $display("FAIL burst_regs: got %h, required %h, pending writes %0d", reg_flat, mdl_flat, exp_wr.size());
        end
    endtask

    task automatic test_rstart_read;
        logic [2:0] a;
        i2c_start;
        wr_byte(8'h4E, a[2]);
        wr_byte(8'h0F, a[1]);
        i2c_start;
        wr_byte(8'h4F, a[0]);
        tests++;
        if (a !== 3'b111) begin fails++; $display("FAIL rstart_acks: got %b, required 111", a); end
        rd_byte(1'b1, 8'h11, "read_byte0");
        rd_byte(1'b0, 8'h22, "read_byte1");
        oe_seen = 1'b0;
        wait_cyc(20);
        sda_m = 1'b0;
        wait_cyc(4);
        tests++;
        if (sda_oe !== 1'b0 || oe_seen) begin
            fails++;
            $display("FAIL oe_after_nack: got sda_oe=%b seen=%b, required 0", sda_oe, oe_seen);
        end
        i2c_stop;
    endtask

    task automatic test_addr_mismatch;
        logic [2:0] a;
        oe_seen = 1'b0;
        i2c_start;
        wr_byte(8'h50, a[2]);
        wr_byte(8'h01, a[1]);
        wr_byte(8'hFF, a[0]);
        i2c_stop;
        tests++;
        if (a !== 3'b000 || oe_seen) begin
            fails++;
            $display("FAIL mismatch_acks: got acks=%b oe_seen=%b, required 000 and 0", a, oe_seen);
        end
        tests++;
        if (reg_flat !== mdl_flat) begin
            fails++;
            $display("FAIL mismatch_regs: got %h, required %h", reg_flat, mdl_flat);
        end
    endtask

    task automatic test_bad_ptr;
        logic [2:0] a;
        i2c_start;
        wr_byte(8'h4E, a[2]);
        wr_byte(8'h10, a[1]);
        wr_byte(8'h77, a[0]);
        i2c_stop;
        tests++;
        if (a !== 3'b100) begin fails++; $display("FAIL badptr_acks: got %b, required 100", a); end
        tests++;
        if (reg_flat !== mdl_flat) begin
            fails++;
            $display("FAIL badptr_regs: got %h, required %h", reg_flat, mdl_flat);
        end
    endtask

    task automatic test_glitch;
        logic [2:0] a;
        i2c_start;
        wr_byte(8'h4E, a[2]);
        wr_byte(8'h05, a[1]);
        glitch = 1'b1;
        wr_data_byte(4'd5, 8'h3C, a[0]);
        glitch = 1'b0;
        i2c_stop;
        tests++;
        if (a !== 3'b111) begin fails++; $display("FAIL glitch_acks: got %b, required 111", a); end
        tests++;
        if (reg_flat !== mdl_flat || exp_wr.size() != 0) begin
            fails++;
            $display("FAIL glitch_regs: got %h, required %h, pending writes %0d", reg_flat, mdl_flat, exp_wr.size());
        end
    endtask

    task automatic test_reset_mid_read;
        logic [2:0] a;
        i2c_start;
        wr_byte(8'h4E, a[2]);
        wr_byte(8'h00, a[1]);
        i2c_start;
        wr_byte(8'h4F, a[0]);
        tests++;
        if (a !== 3'b111 || sda_oe !== 1'b1) begin
            fails++;
            $display("FAIL rd_drive: got acks=%b sda_oe=%b, required 111 and 1", a, sda_oe);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (sda_oe !== 1'b0) begin fails++; $display("FAIL async_reset_oe: got %b, required 0", sda_oe); end
        mdl_flat = '0;
        wait_cyc(2);
        tests++;
        if (reg_flat !== mdl_flat || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_state: got regs=%h busy=%b, required 0", reg_flat, busy);
        end
        rst_n = 1'b1;
        wait_cyc(4);
        i2c_stop;
        i2c_start;
        wr_byte(8'h4F, a[0]);
        tests++;
        if (a[0] !== 1'b1) begin fails++; $display("FAIL post_reset_ack: got %b, required 1", a[0]); end
        rd_byte(1'b0, 8'h00, "read_after_reset");
        i2c_stop;
    endtask

    initial begin
        test_reset;
        test_write;
        test_burst_wrap;
        test_rstart_read;
        test_addr_mismatch;
        test_bad_ptr;
        test_glitch;
        test_reset_mid_read;
        tests++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: pending writes %0d reads %0d, required 0", exp_wr.size(), exp_rd.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
